// File: rtl/fifo_uart_tx.sv
// Pops one byte at a time from a synchronous FIFO and sends it as an 8N1 UART
// frame; frames run back-to-back while the FIFO has data and tx_en is high.
module fifo_uart_tx #(
  parameter int CLOCK_FREQ       = 125_000_000,
  parameter int BAUD_RATE        = 115_200,
  parameter int WIDTH            = 8,
  parameter int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_en,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             fifo_rd_en,
  output logic             serial_out,
  output logic             busy,
  output logic [15:0]      frames_sent
);

  localparam int FRAME_BITS = WIDTH + 2;
  localparam int BAUD_W     = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(SYMBOL_EDGE_TIME - 1);
  localparam logic [3:0]        BIT_LAST  = 4'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND
  } state_t;

  state_t                  state_reg, state_next;
  logic [FRAME_BITS-1:0]   shift_reg, shift_next;
  logic [BAUD_W-1:0]       baud_cnt_reg, baud_cnt_next;
  logic [3:0]              bit_cnt_reg, bit_cnt_next;
  logic [15:0]             frames_sent_reg, frames_sent_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      shift_reg       <= '1;
      baud_cnt_reg    <= '0;
      bit_cnt_reg     <= '0;
      frames_sent_reg <= '0;
    end else begin
      state_reg       <= state_next;
      shift_reg       <= shift_next;
      baud_cnt_reg    <= baud_cnt_next;
      bit_cnt_reg     <= bit_cnt_next;
      frames_sent_reg <= frames_sent_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    shift_next       = shift_reg;
    baud_cnt_next    = baud_cnt_reg;
    bit_cnt_next     = bit_cnt_reg;
    frames_sent_next = frames_sent_reg;
    fifo_rd_en       = 1'b0;

    case (state_reg)
      IDLE: begin
        fifo_rd_en = tx_en && !fifo_empty;
        if (fifo_rd_en) state_next = FETCH;
      end
      FETCH: begin
        shift_next    = {1'b1, fifo_dout, 1'b0};
        baud_cnt_next = '0;
        bit_cnt_next  = '0;
        state_next    = SEND;
      end
      SEND: begin
        if (baud_cnt_reg == BAUD_LAST) begin
          // Ones shift in behind the frame, so the register idles at all-ones.
          baud_cnt_next = '0;
          shift_next    = {1'b1, shift_reg[FRAME_BITS-1:1]};
          bit_cnt_next  = bit_cnt_reg + 4'd1;
          if (bit_cnt_reg == BIT_LAST) begin
            state_next       = IDLE;
            frames_sent_next = frames_sent_reg + 16'd1;
          end
        end else begin
          baud_cnt_next = baud_cnt_reg + BAUD_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The line comes straight from a flop: outside SEND the shifter is all-ones.
  assign serial_out  = shift_reg[0];
  assign busy        = (state_reg != IDLE);
  assign frames_sent = frames_sent_reg;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO model, line decoder and scoreboard of expected
// line patterns, driven from a table of bytes plus hand-timed corner sequences.
module tb_fifo_uart_tx;

  localparam int S = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_en;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_dout = 8'h00;
  logic        fifo_rd_en;
  logic        serial_out;
  logic        busy;
  logic [15:0] frames_sent;

  fifo_uart_tx #(
    .CLOCK_FREQ(1000),
    .BAUD_RATE (100),
    .WIDTH     (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_en      (tx_en),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .serial_out (serial_out),
    .busy       (busy),
    .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;   // line level of bit k at position k (start..stop)
  } vec_t;

  vec_t       vec [6];
  logic [7:0] fifo_mem [$];
  logic [9:0] sb [$];
  int         pop_q [$];
  int         pop_hist [$];
  int         cyc = 0;
  int         rst_cnt = 0;
  int         n_checks = 0;
  int         n_err = 0;
  int         frame_idx = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int idx);
    fifo_mem.push_back(vec[idx].data);
    sb.push_back(vec[idx].line);
  endtask

  task automatic wait_frames(input logic [15:0] target, input int budget);
    int n = 0;
    while (frames_sent !== target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("frames_sent_reach", 32'(frames_sent), 32'(target));
  endtask

  task automatic wait_rd_en(input int budget, output int at_cyc);
    int n = 0;
    while (fifo_rd_en !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("rd_en_seen", 32'(fifo_rd_en), 32'd1);
    at_cyc = cyc;
  endtask

  // Registered-read FIFO model; also logs pop cycles and reset edges.
  always @(posedge clk) begin
    if (rst) rst_cnt++;
    if (fifo_rd_en) begin
      check("rd_en_only_when_nonempty", 32'(fifo_empty), 32'd0);
      if (fifo_mem.size() > 0) begin
        fifo_dout <= fifo_mem.pop_front();
        pop_q.push_back(cyc);
        pop_hist.push_back(cyc);
      end
    end
    fifo_empty <= (fifo_mem.size() == 0);
    cyc <= cyc + 1;
  end

  // Line decoder: samples mid-bit, compares against scoreboard head.
  logic [9:0] mon_bits;
  int         mon_start, mon_rst0;
  bit         mon_abort;
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && serial_out === 1'b0) begin
        mon_start = cyc;
        mon_rst0  = rst_cnt;
        mon_abort = 1'b0;
        mon_bits  = '0;
        for (int c = 0; c < 10 * S; c++) begin
          if (c > 0) @(negedge clk);
          if (rst_cnt != mon_rst0) begin
            mon_abort = 1'b1;
            break;
          end
          if (c % S == S / 2) mon_bits[c / S] = serial_out;
        end
        if (mon_abort) begin
          if (sb.size() > 0) void'(sb.pop_front());
          if (pop_q.size() > 0) void'(pop_q.pop_front());
          $display("frame started at cycle %0d aborted by reset", mon_start);
        end else begin
          frame_idx++;
          check("frame_expected", 32'(sb.size() > 0), 32'd1);
          if (sb.size() > 0) check("frame_bits", 32'(mon_bits), 32'(sb.pop_front()));
          check("frame_has_pop", 32'(pop_q.size() > 0), 32'd1);
          if (pop_q.size() > 0) check("start_latency", 32'(mon_start - pop_q.pop_front()), 32'd2);
          $display("frame %0d: data %02h start cycle %0d", frame_idx, mon_bits[8:1], mon_start);
        end
      end
    end
  end

  int n0, m0, r0, p0, viol;
  logic [15:0] f0;

  initial begin
    vec[0] = '{8'hA5, 10'h34A};
    vec[1] = '{8'h00, 10'h200};
    vec[2] = '{8'hFF, 10'h3FE};
    vec[3] = '{8'h3C, 10'h278};
    vec[4] = '{8'h5A, 10'h2B4};
    vec[5] = '{8'h81, 10'h302};

    rst   = 1'b1;
    tx_en = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_serial_out", 32'(serial_out), 32'd1);
    check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frames_sent", 32'(frames_sent), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single byte with exact cycle timing
    tx_en = 1'b1;
    push(0);
    wait_rd_en(10, n0);
    check("pop_cycle_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("fetch_busy", 32'(busy), 32'd1);
    check("fetch_rd_en", 32'(fifo_rd_en), 32'd0);
    check("fetch_line", 32'(serial_out), 32'd1);
    @(negedge clk);
    check("start_bit_n2", 32'(serial_out), 32'd0);
    while (cyc < n0 + 101) @(negedge clk);
    check("busy_last_cycle", 32'(busy), 32'd1);
    check("frames_before_end", 32'(frames_sent), 32'd0);
    @(negedge clk);
    check("busy_after_frame", 32'(busy), 32'd0);
    check("frames_at_n102", 32'(frames_sent), 32'd1);
    repeat (20) @(negedge clk);
    check("busy_stays_low", 32'(busy), 32'd0);

    // Table of single frames
    for (int i = 0; i < 6; i++) begin
      f0 = frames_sent;
      push(i);
      wait_frames(f0 + 16'd1, 150);
    end

    // Back-to-back 0x00, 0xFF, 0x3C
    f0 = frames_sent;
    p0 = pop_hist.size();
    push(1); push(2); push(3);
    wait_frames(f0 + 16'd3, 400);
    check("b2b_pop_count", 32'(pop_hist.size() - p0), 32'd3);
    if (pop_hist.size() >= p0 + 3) begin
      check("b2b_spacing_1", 32'(pop_hist[p0+1] - pop_hist[p0]), 32'd102);
      check("b2b_spacing_2", 32'(pop_hist[p0+2] - pop_hist[p0+1]), 32'd102);
    end

    // Empty FIFO with tx_en high
    viol = 0;
    repeat (500) begin
      @(negedge clk);
      if (fifo_rd_en !== 1'b0 || serial_out !== 1'b1 || busy !== 1'b0) viol++;
    end
    check("empty_idle_violations", 32'(viol), 32'd0);

    // Gating by tx_en
    tx_en = 1'b0;
    push(3); push(4);
    f0 = frames_sent;
    p0 = pop_hist.size();
    viol = 0;
    repeat (30) begin
      @(negedge clk);
      if (fifo_rd_en !== 1'b0) viol++;
    end
    check("gated_rd_en", 32'(viol), 32'd0);
    check("gated_no_pop", 32'(pop_hist.size() - p0), 32'd0);
    tx_en = 1'b1;
    #1;
    check("gate_open_same_cycle", 32'(fifo_rd_en), 32'd1);
    m0 = cyc;
    @(negedge clk);
    check("gate_pop_cycle", 32'(pop_hist[pop_hist.size()-1]), 32'(m0));
    while (cyc < m0 + 2 + 4 * S + 3) @(negedge clk);
    tx_en = 1'b0;
    wait_frames(f0 + 16'd1, 150);
    p0 = pop_hist.size();
    repeat (150) @(negedge clk);
    check("no_pop_after_drop", 32'(pop_hist.size() - p0), 32'd0);
    check("byte_left_in_fifo", 32'(fifo_mem.size()), 32'd1);

    // Reset at bit 5 of 0x5A
    tx_en = 1'b1;
    r0 = cyc;
    while (cyc < r0 + 2 + 5 * S + 2) @(negedge clk);
    check("busy_before_reset", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("reset_mid_serial_out", 32'(serial_out), 32'd1);
    check("reset_mid_busy", 32'(busy), 32'd0);
    check("reset_mid_frames", 32'(frames_sent), 32'd0);
    push(5);
    wait_frames(16'd1, 150);

    // Counter wrap from a preloaded 0xFFFF
    force dut.frames_sent_reg = 16'hFFFF;
    @(negedge clk);
    release dut.frames_sent_reg;
    @(negedge clk);
    check("preload_frames", 32'(frames_sent), 32'hFFFF);
    push(0);
    wait_frames(16'h0000, 150);
    repeat (20) @(negedge clk);
    check("wrap_busy", 32'(busy), 32'd0);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    check("pops_all_framed", 32'(pop_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
